// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard, redirect, MDU-stall and debug-halt sequencing for the core.
// Ports: hazard sources in; pc/if_id/id_ex/ex stall+flush out; halt_ack; stall/flush counters.
module pipe_ctrl #(
  parameter int REG_IDX_WIDTH = 5,
  parameter int DRAIN_CYCLES  = 4,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_rs1_en_i,
  input  logic                     id_rs2_en_i,
  input  logic [REG_IDX_WIDTH-1:0] id_rs1_idx_i,
  input  logic [REG_IDX_WIDTH-1:0] id_rs2_idx_i,
  input  logic                     ex_rd_en_i,
  input  logic [REG_IDX_WIDTH-1:0] ex_rd_idx_i,
  input  logic                     ex_is_load_i,
  input  logic                     ex_redirect_i,
  input  logic                     mdu_start_i,
  input  logic                     mdu_done_i,
  input  logic                     ifu_valid_i,
  input  logic                     halt_req_i,
  output logic                     pc_stall_o,
  output logic                     pc_redirect_o,
  output logic                     if_id_stall_o,
  output logic                     if_id_flush_o,
  output logic                     id_ex_stall_o,
  output logic                     id_ex_flush_o,
  output logic                     ex_stall_o,
  output logic                     halt_ack_o,
  output logic [CNT_WIDTH-1:0]     stall_cnt_o,
  output logic [CNT_WIDTH-1:0]     flush_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN,
    S_MDU,
    S_DRAIN,
    S_HALT
  } state_e;

  localparam int DW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT =
    DW'(DRAIN_CYCLES - 1);

  state_e               state_q, state_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic                 ret_q, ret_d;
  logic                 ack_q, ack_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic rd_ok, rs1_hit, rs2_hit, lu, mdu_go;

  assign rd_ok   = ex_is_load_i & ex_rd_en_i
                 & (ex_rd_idx_i != '0);
  assign rs1_hit = id_rs1_en_i
                 & (id_rs1_idx_i == ex_rd_idx_i);
  assign rs2_hit = id_rs2_en_i
                 & (id_rs2_idx_i == ex_rd_idx_i);
  assign lu      = rd_ok & (rs1_hit | rs2_hit);
  assign mdu_go  = mdu_start_i & ~mdu_done_i;

  always_comb begin
    pc_stall_o    = 1'b0;
    pc_redirect_o = 1'b0;
    if_id_stall_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_stall_o = 1'b0;
    id_ex_flush_o = 1'b0;
    ex_stall_o    = 1'b0;
    state_d       = state_q;
    drain_d       = drain_q;
    ret_d         = ret_q;
    unique case (state_q)
      S_RUN: begin
        if (ex_redirect_i) begin
          pc_redirect_o = 1'b1;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (mdu_go) begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_stall_o = 1'b1;
          ex_stall_o    = 1'b1;
          state_d       = S_MDU;
          ret_d         = 1'b0;
        end else if (lu) begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (!ifu_valid_i) begin
          pc_stall_o    = 1'b1;
          if_id_flush_o = 1'b1;
        end
        if (halt_req_i && (ex_redirect_i || !mdu_go)) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      S_MDU: begin
        if (!mdu_done_i) begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_stall_o = 1'b1;
          ex_stall_o    = 1'b1;
        end else begin
          state_d = ret_q ? S_DRAIN : S_RUN;
        end
      end
      S_DRAIN: begin
        // PC stays held even on redirect; pc_reg
        // still loads the target via pc_redirect.
        pc_stall_o    = 1'b1;
        if_id_flush_o = 1'b1;
        if (ex_redirect_i) begin
          pc_redirect_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (mdu_go) begin
          if_id_stall_o = 1'b1;
          id_ex_stall_o = 1'b1;
          ex_stall_o    = 1'b1;
        end else if (lu) begin
          if_id_stall_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end
        if (!ex_redirect_i && mdu_go) begin
          // drain_q is left untouched and resumes
          // after the MDU op completes.
          state_d = S_MDU;
          ret_d   = halt_req_i;
        end else if (!halt_req_i) begin
          state_d = S_RUN;
        end else if (ex_redirect_i || !lu) begin
          if (drain_q == '0) state_d = S_HALT;
          else drain_d = drain_q - DW'(1);
        end
      end
      S_HALT: begin
        pc_stall_o    = 1'b1;
        if_id_flush_o = 1'b1;
        if (!halt_req_i) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    ack_d       = (state_d == S_HALT);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall_o && state_q != S_HALT)
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    if (pc_redirect_o)
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      drain_q     <= '0;
      ret_q       <= 1'b0;
      ack_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      ret_q       <= ret_d;
      ack_q       <= ack_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halt_ack_o  = ack_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard and sequencing controller for the riscx in-order core. Takes hazard sources from the decode, execute, fetch and multiply/divide units and drives the stall, flush and redirect controls of `pc_reg`, `if_id`, `id_ex` and the EX stage. Also sequences a debug halt by draining the pipeline, and keeps stall and flush performance counters.

## Interface
- `REG_IDX_WIDTH`, default 5: register index width.
- `DRAIN_CYCLES`, default 4: cycles spent in DRAIN before the halt is acknowledged; must be at least 1.
- `CNT_WIDTH`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_rs1_en_i` / `id_rs2_en_i`  in  1  decode reads rs1 / rs2.
- `id_rs1_idx_i` / `id_rs2_idx_i`  in  REG_IDX_WIDTH  decode source indices.
- `ex_rd_en_i`  in  1  EX instruction writes rd.
- `ex_rd_idx_i`  in  REG_IDX_WIDTH  EX destination index.
- `ex_is_load_i`  in  1  EX instruction is a load.
- `ex_redirect_i`  in  1  EX resolved a taken branch or jump.
- `mdu_start_i`  in  1  multi-cycle MDU op issued from EX (pulse).
- `mdu_done_i`  in  1  MDU result valid (pulse).
- `ifu_valid_i`  in  1  fetched instruction valid this cycle.
- `halt_req_i`  in  1  debug halt request (level).
- `pc_stall_o`  out  1  hold PC.
- `pc_redirect_o`  out  1  PC selects the EX target.
- `if_id_stall_o` / `if_id_flush_o`  out  1  hold / bubble IF_ID.
- `id_ex_stall_o` / `id_ex_flush_o`  out  1  hold / bubble ID_EX.
- `ex_stall_o`  out  1  hold EX / EX_MEM.
- `halt_ack_o`  out  1  pipeline halted (registered).
- `stall_cnt_o`  out  CNT_WIDTH  count of stall cycles.
- `flush_cnt_o`  out  CNT_WIDTH  count of redirects.

## Operation
- FSM states: RUN, MDU_BUSY, DRAIN, HALTED. Reset state is RUN.
- Load-use hazard (`lu`) is asserted when all of the following hold:
  - `ex_is_load_i`, `ex_rd_en_i`, and `ex_rd_idx_i != 0`;
  - and either `id_rs1_en_i` with `id_rs1_idx_i == ex_rd_idx_i`, or `id_rs2_en_i` with `id_rs2_idx_i == ex_rd_idx_i`.
- In RUN, the first matching rule applies:
  1. `ex_redirect_i`: `pc_redirect_o`, `if_id_flush_o`, `id_ex_flush_o`; `flush_cnt` +1.
  2. `mdu_start_i & !mdu_done_i`: `pc_stall_o`, `if_id_stall_o`, `id_ex_stall_o`, `ex_stall_o`; next state MDU_BUSY. If start and done arrive in the same cycle, no stall and the FSM stays in RUN.
  3. `lu`: `pc_stall_o`, `if_id_stall_o`, `id_ex_flush_o` (one bubble).
  4. `!ifu_valid_i`: `pc_stall_o`, `if_id_flush_o`.
  5. Otherwise all controls are 0.
  - Independently of rules 1-5: if `halt_req_i` is set and rule 2 did not fire, next state is DRAIN and the drain counter loads `DRAIN_CYCLES-1`.
- MDU_BUSY:
  - Stall set (`pc`, `if_id`, `id_ex`, `ex`) is asserted while `!mdu_done_i`.
  - In the `mdu_done_i` cycle all stalls are 0 and next state is RUN.
  - `ex_redirect_i`, `lu` and `halt_req_i` are ignored.
- DRAIN:
  - `pc_stall_o` and `if_id_flush_o` are asserted every cycle; no new fetch enters.
  - Redirect, MDU and `lu` are handled as in RUN, but a redirect leaves PC stalled, and `pc_redirect_o` still asserts so `pc_reg` loads the target.
  - MDU start moves to MDU_BUSY, then returns to DRAIN with the remaining count, which is saved.
  - The counter decrements only when no stall is active (`lu` or MDU).
  - At count 0 the next state is HALTED.
  - Dropping `halt_req_i` in DRAIN returns to RUN.
- HALTED: `pc_stall_o`, `if_id_flush_o` and `halt_ack_o` are 1. When `halt_req_i` is 0, next state is RUN.
- `stall_cnt`: +1 on every cycle where `pc_stall_o` is 1 and the state is not HALTED.
- Both counters wrap modulo 2^CNT_WIDTH.
- `pc_redirect_o` and a stall never assert together in RUN.

## Timing
- All control outputs are combinational from the current state and inputs. They act at the next `clk` rising edge.
- `halt_ack_o`, the counters and the state are registered.
- Reset values: state RUN, drain count 0, `halt_ack_o` 0, `stall_cnt_o` 0, `flush_cnt_o` 0.
- With idle inputs (`ifu_valid_i`=1, others 0), all control outputs are 0 during reset.
- Asserting `rst_n` low mid-MDU or mid-DRAIN forces RUN immediately. The MDU owner aborts its op on the same reset.
- Load-use costs exactly 1 bubble: on the next cycle the load is in MEM and `lu` is 0.
- An MDU op with done arriving N cycles after start stalls for N cycles.
- Halt latency: with no hazards, `halt_ack_o` rises `DRAIN_CYCLES`+1 edges after the first cycle `halt_req_i` is seen in RUN.
- `halt_ack_o` falls 1 edge after `halt_req_i` deasserts.

## Test plan
- Load `x5` in EX while ID reads `x5` via rs2:
  - 1 cycle with `pc_stall`, `if_id_stall` and `id_ex_flush` = 1, and `stall_cnt` = 1;
  - same stimulus with `ex_rd_idx` = 0 gives no stall.
- Redirect and `lu` in the same cycle: `pc_redirect`, `if_id_flush` and `id_ex_flush` = 1, no stall, `flush_cnt` +1.
- `mdu_start` pulse, `mdu_done` 3 cycles later:
  - `ex_stall` high for exactly 3 cycles, and `stall_cnt` = 3;
  - start and done together give 0 stall cycles.
- Hold `halt_req` with `DRAIN_CYCLES`=4 and no hazards:
  - `halt_ack` rises at edge 5 and PC stays stalled;
  - drop `halt_req` and `halt_ack` = 0 after 1 edge, controls return to 0.
- Halt request during MDU_BUSY:
  - DRAIN is entered only after `mdu_done`;
  - a `lu` hit during DRAIN extends the ack by 1 cycle.
- Preload `stall_cnt` to all-ones (force), stall 1 cycle: the counter wraps to 0.
- Pulse `rst_n` low in MDU_BUSY: outputs go to idle values asynchronously.
